// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage.
// Takes one instruction from EXE over a valid/allowin handshake and issues at most
// one data-SRAM transaction for it over a req/addr_ok/data_ok bus. Load data is
// aligned and extended, and store strobes and data are generated from the address.
// The result is passed to WB over a second valid/allowin handshake. A
// forwarding/blocking bundle goes back to ID.
//
// Ports:
//   clk, reset                  clock; asynchronous active-high reset
//   exe_to_mem_valid/mem_allowin
//                               EXE->MEM handshake
//   exe_*                       EXE payload (pc, result/address, load flag, mem
//                               controls, store data, rf write, exceptions)
//   cancel_exc_ertn             flush from WB
//   data_sram_*                 data bus: req/wr/wstrb/addr/wdata out;
//                               addr_ok/data_ok/rdata in
//   wb_allowin/mem_to_wb_valid  MEM->WB handshake
//   mem_pc, mem_final_result, mem_rf_all, mem_exc_rf
//                               WB payload
//   mem_fwd_all                 {mem_blocking, mem_rf_all, mem_final_result}
//
// Configuration: define MEM_ALE_CHECK_EN to enable the misaligned-address check
// (mem_exc_rf[2]). When it is undefined, that bit is tied to zero.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        exe_to_mem_valid,
  output logic        mem_allowin,
  input  logic [31:0] exe_pc,
  input  logic [31:0] exe_result,
  input  logic        exe_res_from_mem,
  input  logic [7:0]  exe_mem_all,
  input  logic [31:0] exe_rkd_value,
  input  logic [5:0]  exe_rf_all,
  input  logic [1:0]  exe_exc_rf,
  input  logic        cancel_exc_ertn,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  input  logic        wb_allowin,
  output logic        mem_to_wb_valid,
  output logic [31:0] mem_pc,
  output logic [31:0] mem_final_result,
  output logic [5:0]  mem_rf_all,
  output logic [2:0]  mem_exc_rf,
  output logic [38:0] mem_fwd_all
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StDone, StDrain} state_e;

  state_e      state_q, state_d, state_new;
  logic        mem_valid_q, mem_valid_d;
  logic [31:0] pc_q, result_q, rkd_q;
  logic        res_from_mem_q;
  logic [7:0]  mem_all_q;
  logic [5:0]  rf_all_q;
  logic [1:0]  exc_q;
  logic        ale_q, ale_in;
  logic        accept;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;

  // mem_all fields: {mem_we, ld_b, ld_h, ld_w, ld_se, st_b, st_h, st_w}
`ifdef MEM_ALE_CHECK_EN
  assign ale_in = ((exe_mem_all[5] | exe_mem_all[1]) & exe_result[0]) |
                  ((exe_mem_all[4] | exe_mem_all[0]) & (exe_result[1:0] != 2'b00));
`else
  assign ale_in = 1'b0;
`endif

  assign mem_allowin = (state_q != StDrain) &
                       (~mem_valid_q | ((state_q == StDone) & wb_allowin));
  assign accept      = exe_to_mem_valid & mem_allowin;

  // Faulting instructions skip the bus entirely.
  assign state_new = ((exe_mem_all[7] | exe_res_from_mem) & ~ale_in & (exe_exc_rf == 2'b00))
                     ? StReq : StDone;

  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d     = state_new;
          mem_valid_d = 1'b1;
        end
      end
      StReq:   if (data_sram_addr_ok) state_d = StWait;
      StWait:  if (data_sram_data_ok) state_d = StDone;
      StDone: begin
        if (wb_allowin) begin
          mem_valid_d = accept;
          state_d     = accept ? state_new : StIdle;
        end
      end
      StDrain: if (data_sram_data_ok) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // A flush must still swallow the response of any request the bus has accepted.
    if (cancel_exc_ertn) begin
      mem_valid_d = 1'b0;
      unique case (state_q)
        StReq:   state_d = data_sram_addr_ok ? StDrain : StIdle;
        StWait:  state_d = data_sram_data_ok ? StIdle : StDrain;
        StDrain: state_d = data_sram_data_ok ? StIdle : StDrain;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    unique case (result_q[1:0])
      2'd0:    ld_byte = data_sram_rdata[7:0];
      2'd1:    ld_byte = data_sram_rdata[15:8];
      2'd2:    ld_byte = data_sram_rdata[23:16];
      default: ld_byte = data_sram_rdata[31:24];
    endcase
    ld_half = result_q[1] ? data_sram_rdata[31:16] : data_sram_rdata[15:0];
    if (mem_all_q[6]) begin
      load_data = {{24{mem_all_q[3] & ld_byte[7]}}, ld_byte};
    end else if (mem_all_q[5]) begin
      load_data = {{16{mem_all_q[3] & ld_half[15]}}, ld_half};
    end else begin
      load_data = data_sram_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      mem_valid_q    <= 1'b0;
      pc_q           <= '0;
      result_q       <= '0;
      rkd_q          <= '0;
      res_from_mem_q <= 1'b0;
      mem_all_q      <= '0;
      rf_all_q       <= '0;
      exc_q          <= '0;
      ale_q          <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      if (accept) begin
        pc_q           <= exe_pc;
        result_q       <= exe_result;
        rkd_q          <= exe_rkd_value;
        res_from_mem_q <= exe_res_from_mem;
        mem_all_q      <= exe_mem_all;
        rf_all_q       <= exe_rf_all;
        exc_q          <= exe_exc_rf;
        ale_q          <= ale_in;
      end else if ((state_q == StWait) & data_sram_data_ok & res_from_mem_q) begin
        result_q <= load_data;
      end
    end
  end

  always_comb begin
    data_sram_wstrb = 4'b0000;
    data_sram_wdata = rkd_q;
    if (mem_all_q[7]) begin
      if (mem_all_q[2]) begin
        unique case (result_q[1:0])
          2'd0:    data_sram_wstrb = 4'b0001;
          2'd1:    data_sram_wstrb = 4'b0010;
          2'd2:    data_sram_wstrb = 4'b0100;
          default: data_sram_wstrb = 4'b1000;
        endcase
        data_sram_wdata = {4{rkd_q[7:0]}};
      end else if (mem_all_q[1]) begin
        data_sram_wstrb = result_q[1] ? 4'b1100 : 4'b0011;
        data_sram_wdata = {2{rkd_q[15:0]}};
      end else if (mem_all_q[0]) begin
        data_sram_wstrb = 4'b1111;
      end
    end
  end

  assign data_sram_req    = (state_q == StReq);
  assign data_sram_wr     = mem_all_q[7];
  assign data_sram_addr   = {result_q[31:2], 2'b00};
  assign mem_to_wb_valid  = mem_valid_q & (state_q == StDone);
  assign mem_pc           = pc_q;
  assign mem_final_result = result_q;
  assign mem_exc_rf       = {ale_q, exc_q};
  assign mem_rf_all       = {rf_all_q[5] & (mem_exc_rf == 3'b000), rf_all_q[4:0]};
  assign mem_fwd_all      = {mem_valid_q & res_from_mem_q & (state_q != StDone),
                             mem_rf_all, mem_final_result};

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        exe_to_mem_valid = 1'b0;
  logic        mem_allowin;
  logic [31:0] exe_pc = '0, exe_result = '0, exe_rkd_value = '0;
  logic        exe_res_from_mem = 1'b0;
  logic [7:0]  exe_mem_all = '0;
  logic [5:0]  exe_rf_all = '0;
  logic [1:0]  exe_exc_rf = '0;
  logic        cancel_exc_ertn = 1'b0;
  logic        data_sram_req, data_sram_wr;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok = 1'b0, data_sram_data_ok = 1'b0;
  logic [31:0] data_sram_rdata = '0;
  logic        wb_allowin = 1'b1;
  logic        mem_to_wb_valid;
  logic [31:0] mem_pc, mem_final_result;
  logic [5:0]  mem_rf_all;
  logic [2:0]  mem_exc_rf;
  logic [38:0] mem_fwd_all;

  mem_stage dut (
    .clk(clk), .reset(reset),
    .exe_to_mem_valid(exe_to_mem_valid), .mem_allowin(mem_allowin),
    .exe_pc(exe_pc), .exe_result(exe_result), .exe_res_from_mem(exe_res_from_mem),
    .exe_mem_all(exe_mem_all), .exe_rkd_value(exe_rkd_value), .exe_rf_all(exe_rf_all),
    .exe_exc_rf(exe_exc_rf), .cancel_exc_ertn(cancel_exc_ertn),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .data_sram_addr_ok(data_sram_addr_ok),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .wb_allowin(wb_allowin), .mem_to_wb_valid(mem_to_wb_valid), .mem_pc(mem_pc),
    .mem_final_result(mem_final_result), .mem_rf_all(mem_rf_all),
    .mem_exc_rf(mem_exc_rf), .mem_fwd_all(mem_fwd_all)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] res;
    logic [5:0]  rf;
    logic [2:0]  exc;
  } wb_t;
  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_t;

  wb_t  wb_q[$];
  req_t rq_q[$];
  int   total = 0, bad = 0;

  // Bus responder knobs: -1 means random.
  int          aok_hold = 0, dlat = 0;
  bit          force_en = 0;
  logic [31:0] force_rdata = '0;
  bit          rand_wb = 0;
  int          reqcyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  // Reference behaviour of one instruction, from the architectural rules.
  function automatic void model(input logic [31:0] pc, input logic [31:0] a, input logic rfm,
                                input logic [7:0] ma, input logic [31:0] rkd,
                                input logic [5:0] rf, input logic [1:0] exc,
                                output wb_t w, output req_t r, output bit has_req);
    int unsigned off, word, v;
    bit ale;
    off  = a % 4;
    ale  = 0;
`ifdef MEM_ALE_CHECK_EN
    if ((ma[5] || ma[1]) && (off % 2) != 0) ale = 1;
    if ((ma[4] || ma[0]) && off != 0) ale = 1;
`endif
    has_req = (ma[7] || rfm) && !ale && exc == 0;
    w.pc  = pc;
    w.exc = {ale, exc};
    w.rf  = (w.exc != 0) ? {1'b0, rf[4:0]} : rf;
    w.res = a;
    word  = mem_word(a - off);
    if (has_req && rfm) begin
      if (ma[6]) begin
        v = (word >> (8 * off)) % 256;
        if (ma[3] && v >= 128) v = v + 32'hFFFF_FF00;
      end else if (ma[5]) begin
        v = (off >= 2) ? word / 65536 : word % 65536;
        if (ma[3] && v >= 32768) v = v + 32'hFFFF_0000;
      end else begin
        v = word;
      end
      w.res = v;
    end
    r.addr  = a - off;
    r.wr    = ma[7];
    r.wstrb = 0;
    r.wdata = rkd;
    if (ma[7] && ma[2]) begin
      r.wstrb = 4'(1 << off);
      r.wdata = (rkd % 256) * 32'h0101_0101;
    end else if (ma[7] && ma[1]) begin
      r.wstrb = (off >= 2) ? 4'b1100 : 4'b0011;
      r.wdata = (rkd % 65536) * 32'h0001_0001;
    end else if (ma[7] && ma[0]) begin
      r.wstrb = 4'hF;
    end
  endfunction

  // push: 0 nothing, 1 WB and request, 2 request only
  task automatic issue(input logic [31:0] pc, input logic [31:0] a, input logic rfm,
                       input logic [7:0] ma, input logic [31:0] rkd, input logic [5:0] rf,
                       input logic [1:0] exc, input int push);
    int   n;
    bit   fired, hr;
    wb_t  w;
    req_t r;
    n = 0;
    fired = 0;
    exe_pc = pc; exe_result = a; exe_res_from_mem = rfm; exe_mem_all = ma;
    exe_rkd_value = rkd; exe_rf_all = rf; exe_exc_rf = exc; exe_to_mem_valid = 1'b1;
    while (!fired && n < 300) begin
      @(negedge clk);
      fired = mem_allowin;
      @(posedge clk);
      #1;
      n++;
    end
    exe_to_mem_valid = 1'b0;
    if (!fired) begin
      chk("issue_timeout", 0, 1);
    end else begin
      model(pc, a, rfm, ma, rkd, rf, exc, w, r, hr);
      if (push == 1) wb_q.push_back(w);
      if (push != 0 && hr) rq_q.push_back(r);
    end
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while ((wb_q.size() != 0 || rq_q.size() != 0) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, 64'(wb_q.size() + rq_q.size()), 0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Bus responder: one outstanding request, fixed or random latency.
  initial begin
    bit          f_req, f_dok, pend;
    int          cnt;
    logic [31:0] f_addr, pdata;
    pend = 0;
    cnt  = 0;
    pdata = '0;
    forever begin
      @(negedge clk);
      f_req  = data_sram_req && data_sram_addr_ok;
      f_addr = data_sram_addr;
      f_dok  = data_sram_data_ok;
      if (data_sram_req && !data_sram_addr_ok) reqcyc++;
      else reqcyc = 0;
      @(posedge clk);
      #1;
      if (f_dok) pend = 0;
      if (f_req) begin
        pend  = 1;
        cnt   = (dlat < 0) ? int'($urandom_range(0, 3)) : dlat;
        pdata = force_en ? force_rdata : mem_word(f_addr);
      end
      if (reset) pend = 0;
      data_sram_data_ok = 1'b0;
      data_sram_rdata   = $urandom;
      if (pend) begin
        if (cnt == 0) begin
          data_sram_data_ok = 1'b1;
          data_sram_rdata   = pdata;
        end else begin
          cnt--;
        end
      end
      if (aok_hold < 0) data_sram_addr_ok = data_sram_req && ($urandom % 2 == 0);
      else data_sram_addr_ok = data_sram_req && (reqcyc >= aok_hold);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      wb_allowin = rand_wb ? ($urandom % 4 != 0) : 1'b1;
    end
  end

  // Monitor: pops expected bus requests and WB handoffs.
  initial begin
    wb_t  w;
    req_t r;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (data_sram_req && data_sram_addr_ok) begin
          if (rq_q.size() == 0) begin
            chk("unexpected_req", 1, 0);
          end else begin
            r = rq_q.pop_front();
            chk("req_addr", data_sram_addr, r.addr);
            chk("req_wr", data_sram_wr, r.wr);
            chk("req_wstrb", data_sram_wstrb, r.wstrb);
            if (r.wr) chk("req_wdata", data_sram_wdata, r.wdata);
          end
        end
        if (mem_to_wb_valid && wb_allowin) begin
          if (wb_q.size() == 0) begin
            chk("unexpected_wb", 1, 0);
          end else begin
            w = wb_q.pop_front();
            chk("wb_pc", mem_pc, w.pc);
            chk("wb_result", mem_final_result, w.res);
            chk("wb_rf", mem_rf_all, w.rf);
            chk("wb_exc", mem_exc_rf, w.exc);
            chk("wb_fwd", mem_fwd_all, {1'b0, w.rf, w.res});
          end
        end
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_allowin"}, mem_allowin, 1);
    chk({tag, "_req"}, data_sram_req, 0);
    chk({tag, "_wr"}, data_sram_wr, 0);
    chk({tag, "_wstrb"}, data_sram_wstrb, 0);
    chk({tag, "_addr"}, data_sram_addr, 0);
    chk({tag, "_towb"}, mem_to_wb_valid, 0);
    chk({tag, "_pc"}, mem_pc, 0);
    chk({tag, "_result"}, mem_final_result, 0);
    chk({tag, "_exc"}, mem_exc_rf, 0);
    chk({tag, "_fwd"}, mem_fwd_all, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    wb_t w;
    @(negedge clk);
    chk_reset_vals("reset");
    @(posedge clk);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Non-memory op: result passes through, WB valid in the accept cycle.
    issue(32'h100, 32'h1234, 0, 8'h00, 0, 6'h23, 0, 1);
    @(negedge clk);
    chk("alu_towb", mem_to_wb_valid, 1);
    chk("alu_req", data_sram_req, 0);
    wait_empty("alu_drain");

    // ld.b sign-extended at byte 3.
    aok_hold = 0; dlat = 0; force_en = 1; force_rdata = 32'h80FF_0000;
    issue(32'h104, 32'h1003, 1, 8'b0100_1000, 0, 6'h21, 0, 0);
    rq_q.push_back('{addr: 32'h1000, wr: 1'b0, wstrb: 4'h0, wdata: 32'h0});
    w.pc = 32'h104; w.res = 32'hFFFF_FF80; w.rf = 6'h21; w.exc = 0;
    wb_q.push_back(w);
    @(negedge clk);
    chk("ldb_req", data_sram_req, 1);
    chk("ldb_blocking", mem_fwd_all[38], 1);
    @(negedge clk);
    chk("ldb_dataok", data_sram_data_ok, 1);
    chk("ldb_towb_early", mem_to_wb_valid, 0);
    @(negedge clk);
    chk("ldb_towb", mem_to_wb_valid, 1);
    force_en = 0;
    wait_empty("ldb_drain");

    // st.h at upper half with addr_ok held low for 3 cycles.
    aok_hold = 3;
    issue(32'h108, 32'h2002, 0, 8'b1000_0010, 32'h0000_ABCD, 6'h00, 0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("sth_req", data_sram_req, 1);
      chk("sth_aok", data_sram_addr_ok, 0);
      chk("sth_addr", data_sram_addr, 32'h2000);
      chk("sth_wstrb", data_sram_wstrb, 4'b1100);
      chk("sth_wdata", data_sram_wdata, 32'hABCD_ABCD);
      chk("sth_wr", data_sram_wr, 1);
    end
    aok_hold = 0;
    wait_empty("sth_drain");

    // Flush in WAIT: response arrives 4 cycles later and is discarded.
    dlat = 4;
    issue(32'h10C, 32'h40, 1, 8'b0001_0000, 0, 6'h22, 0, 2);
    @(posedge clk);
    #1;
    cancel_exc_ertn = 1'b1;
    @(posedge clk);
    #1;
    cancel_exc_ertn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("drain_allowin", mem_allowin, 0);
      chk("drain_towb", mem_to_wb_valid, 0);
      chk("drain_req", data_sram_req, 0);
    end
    @(negedge clk);
    chk("drain_done_allowin", mem_allowin, 1);
    dlat = 0;
    wait_empty("cancel_drain");

    // Misaligned ld.w.
    issue(32'h110, 32'h3001, 1, 8'b0001_0000, 0, 6'h25, 0, 1);
    @(negedge clk);
`ifdef MEM_ALE_CHECK_EN
    chk("ale_req", data_sram_req, 0);
    chk("ale_exc", mem_exc_rf, 3'b100);
    chk("ale_rfwe", mem_rf_all[5], 0);
`else
    chk("ale_req", data_sram_req, 1);
    chk("ale_addr", data_sram_addr, 32'h3000);
`endif
    wait_empty("ale_drain");

    // Reset in WAIT, then a load completes normally.
    dlat = 5;
    issue(32'h114, 32'h500, 1, 8'b0001_0000, 0, 6'h26, 0, 2);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("midrst");
    @(posedge clk);
    #3;
    reset = 1'b0;
    dlat = 1;
    issue(32'h118, 32'h504, 1, 8'b0001_0000, 0, 6'h27, 0, 1);
    wait_empty("post_reset");

    // Randomized traffic with back-pressure and random bus timing.
    aok_hold = -1; dlat = -1; rand_wb = 1;
    for (int i = 0; i < 200; i++) begin
      int unsigned k, sz;
      logic [7:0]  ma;
      logic        rfm;
      logic [1:0]  exc;
      k   = $urandom % 8;
      sz  = $urandom % 3;
      rfm = 0;
      ma  = 8'h00;
      if (k >= 2 && k <= 4) begin
        rfm = 1;
        ma  = {1'b0, sz == 0, sz == 1, sz == 2, 1'($urandom % 2), 3'b000};
      end else if (k >= 5) begin
        ma = {1'b1, 4'b0000, sz == 0, sz == 1, sz == 2};
      end
      exc = ($urandom % 10 == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      issue($urandom, $urandom, rfm, ma, $urandom, 6'($urandom), exc, 1);
      repeat ($urandom % 3) begin
        @(posedge clk);
        #1;
      end
    end
    wait_empty("random_drain");
    rand_wb = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
